// File: rtl/msx_pkg.sv
// Shared MSX bus constants and slot-field helpers used by the slot expander
// and other bus-register blocks.
package msx_pkg;

  localparam logic [7:0]  PORT_PSL      = 8'hA8;
  localparam logic [7:0]  PORT_SEG_BASE = 8'hFC;
  localparam logic [15:0] ADDR_SSL      = 16'hFFFF;

  typedef enum logic {
    WC_IDLE = 1'b0,
    WC_HELD = 1'b1
  } wc_state_e;

  // Two-bit field for a 16 KB page out of a slot-select style register.
  function automatic logic [1:0] page_field(input logic [7:0] r, input logic [1:0] page);
    return r[2*page +: 2];
  endfunction

  // Power-on segment for mapper page p is 3-p, i.e. a linear 64 KB layout.
  function automatic logic [7:0] reset_seg(input logic [1:0] p);
    return {6'b0, ~p};
  endfunction

endpackage

// File: rtl/msx_bus_wr_commit.sv
// Single-commit write FSM: one commit pulse per bus write no matter how many
// wait states stretch the strobe.
module msx_bus_wr_commit
  import msx_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic req_i,
  input  logic hold_i,
  output logic commit_o
);

  wc_state_e state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WC_IDLE;
    end else begin
      case (state_q)
        WC_IDLE: if (req_i)   state_q <= WC_HELD;
        WC_HELD: if (!hold_i) state_q <= WC_IDLE;
        default:              state_q <= WC_IDLE;
      endcase
    end
  end

  // Commit lands on the same edge that moves IDLE -> HELD.
  assign commit_o = (state_q == WC_IDLE) && req_i;

endmodule

// File: rtl/msx_slot_expander.sv
// Primary/secondary slot decoder with slot registers and a RAM mapper.
// Selects and read data are combinational from registers and bus strobes.
module msx_slot_expander
  import msx_pkg::*;
#(
  parameter logic [3:0] EXPANDED    = 4'b1000,
  parameter int         SEG_BITS    = 3,
  parameter logic [1:0] MAPPER_SLOT = 2'd3,
  parameter logic [1:0] MAPPER_SUB  = 2'd0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [15:0]          addr,
  input  logic [7:0]           d_from_cpu,
  input  logic                 mreq_n,
  input  logic                 iorq_n,
  input  logic                 rd_n,
  input  logic                 wr_n,
  input  logic                 m1_n,
  input  logic                 rfrsh_n,
  output logic [7:0]           d_out,
  output logic                 d_oe,
  output logic [3:0]           sltsl_n,
  output logic [15:0]          subsl_n,
  output logic                 mapper_cs_n,
  output logic [SEG_BITS+13:0] mapper_addr,
  output logic                 mapper_we
);

  logic [7:0]          prim_q, prim_d;
  logic [7:0]          secreg_q [4];
  logic [7:0]          secreg_d [4];
  logic [SEG_BITS-1:0] seg_q [4];
  logic [SEG_BITS-1:0] seg_d [4];

  logic [1:0] page, slot, sub, seg_idx;
  logic       slot_exp, mem_cyc, io_cyc, ssl_hit, mem_sel;
  logic       io_psl, io_seg, mapper_hit;
  logic       wr_ssl, wr_psl, wr_seg, wr_req, wr_hold, commit;
  logic [7:0] seg_rd;

  assign page     = addr[15:14];
  assign slot     = page_field(prim_q, page);
  assign sub      = page_field(secreg_q[slot], page);
  assign slot_exp = EXPANDED[slot];
  assign seg_idx  = addr[1:0];

  assign mem_cyc = ~mreq_n & rfrsh_n;
  assign io_cyc  = ~iorq_n & m1_n;

  // FFFFh is only a register when the slot in page 3 is expanded.
  assign ssl_hit = (addr == ADDR_SSL) & slot_exp;
  assign mem_sel = mem_cyc & ~ssl_hit;

  assign io_psl = io_cyc & (addr[7:0] == PORT_PSL);
  assign io_seg = io_cyc & (addr[7:2] == PORT_SEG_BASE[7:2]);

  assign mapper_hit = mem_sel & (slot == MAPPER_SLOT)
                    & (~EXPANDED[MAPPER_SLOT] | (sub == MAPPER_SUB));

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sltsl
      assign sltsl_n[gi] = ~(reset_n & mem_sel & (slot == 2'(gi)));
    end
    for (genvar gi = 0; gi < 16; gi++) begin : g_subsl
      assign subsl_n[gi] = ~(reset_n & mem_sel & EXPANDED[gi/4]
                             & (slot == 2'(gi/4)) & (sub == 2'(gi%4)));
    end
  endgenerate

  assign mapper_cs_n = ~(reset_n & mapper_hit);
  assign mapper_we   = reset_n & mapper_hit & ~wr_n;
  assign mapper_addr = {seg_q[page], addr[13:0]};

  always_comb begin
    seg_rd = 8'hFF;
    seg_rd[SEG_BITS-1:0] = seg_q[seg_idx];
  end

  always_comb begin
    d_out = 8'h00;
    d_oe  = 1'b0;
    if (reset_n && !rd_n) begin
      if (mem_cyc && ssl_hit) begin
        d_out = ~secreg_q[slot];
        d_oe  = 1'b1;
      end else if (io_psl) begin
        d_out = prim_q;
        d_oe  = 1'b1;
      end else if (io_seg) begin
        d_out = seg_rd;
        d_oe  = 1'b1;
      end
    end
  end

  assign wr_ssl  = mem_cyc & ssl_hit & ~wr_n;
  assign wr_psl  = io_psl & ~wr_n;
  assign wr_seg  = io_seg & ~wr_n;
  assign wr_req  = wr_ssl | wr_psl | wr_seg;
  assign wr_hold = ~wr_n & (~mreq_n | ~iorq_n);

  msx_bus_wr_commit u_commit (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_i    (wr_req),
    .hold_i   (wr_hold),
    .commit_o (commit)
  );

  always_comb begin
    prim_d   = prim_q;
    secreg_d = secreg_q;
    seg_d    = seg_q;
    if (commit) begin
      if (wr_psl) prim_d = d_from_cpu;
      if (wr_ssl) secreg_d[slot] = d_from_cpu;
      if (wr_seg) seg_d[seg_idx] = d_from_cpu[SEG_BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prim_q <= 8'h00;
      for (int i = 0; i < 4; i++) begin
        secreg_q[i] <= 8'h00;
        seg_q[i]    <= SEG_BITS'(reset_seg(2'(i)));
      end
    end else begin
      prim_q   <= prim_d;
      secreg_q <= secreg_d;
      seg_q    <= seg_d;
    end
  end

endmodule

// File: tb/tb_msx_slot_expander.sv
// Directed plus randomized bus cycles against an arithmetic model of the
// slot/subslot/mapper rules.
module tb_msx_slot_expander;

  localparam int SEG_BITS = 3;
  localparam int SEG_MASK = (1 << SEG_BITS) - 1;
  localparam int EXP_MASK = 4'b1000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  d_from_cpu = 8'h00;
  logic        mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic        m1_n = 1'b1, rfrsh_n = 1'b1;
  logic [7:0]  d_out;
  logic        d_oe;
  logic [3:0]  sltsl_n;
  logic [15:0] subsl_n;
  logic        mapper_cs_n;
  logic [SEG_BITS+13:0] mapper_addr;
  logic        mapper_we;

  msx_slot_expander #(
    .EXPANDED(4'b1000), .SEG_BITS(SEG_BITS), .MAPPER_SLOT(2'd3), .MAPPER_SUB(2'd0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .d_from_cpu(d_from_cpu),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
    .rfrsh_n(rfrsh_n), .d_out(d_out), .d_oe(d_oe), .sltsl_n(sltsl_n),
    .subsl_n(subsl_n), .mapper_cs_n(mapper_cs_n), .mapper_addr(mapper_addr),
    .mapper_we(mapper_we)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state as plain integers.
  int m_prim;
  int m_sec [4];
  int m_seg [4];

  function automatic void model_reset();
    m_prim = 0;
    for (int i = 0; i < 4; i++) begin
      m_sec[i] = 0;
      m_seg[i] = (3 - i) & SEG_MASK;
    end
  endfunction

  function automatic int slot_of(int a);
    return (m_prim >> (2 * (a / 16384))) % 4;
  endfunction

  function automatic bit is_ssl(int a);
    return (a == 65535) && (((EXP_MASK >> slot_of(a)) & 1) == 1);
  endfunction

  // Register effect of a bus write, evaluated with the state before the edge.
  function automatic void model_write(int a, int d, bit io);
    if (io) begin
      if ((a % 256) == 'hA8) m_prim = d;
      else if ((a % 256) >= 'hFC) m_seg[(a % 256) - 'hFC] = d & SEG_MASK;
    end else if (is_ssl(a)) begin
      m_sec[slot_of(a)] = d;
    end
  endfunction

  task automatic cmp(string tag, int got, int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check(string tag);
    int a, page, slot, sub, ex_sl, ex_sub, ex_cs, ex_we, ex_oe, ex_dout, ex_maddr;
    bit mem, io, expd, ssl;
    a = int'(addr);
    page = a / 16384;
    slot = slot_of(a);
    sub  = (m_sec[slot] >> (2 * page)) % 4;
    expd = ((EXP_MASK >> slot) & 1) == 1;
    mem  = !mreq_n && rfrsh_n;
    io   = !iorq_n && m1_n;
    ssl  = is_ssl(a);
    ex_sl = 'hF; ex_sub = 'hFFFF; ex_cs = 1; ex_we = 0; ex_oe = 0; ex_dout = 0;
    ex_maddr = m_seg[page] * 16384 + (a % 16384);
    if (reset_n) begin
      if (mem && !ssl) begin
        ex_sl &= ~(1 << slot);
        if (expd) ex_sub &= ~(1 << (4 * slot + sub));
        if (slot == 3 && (!expd || sub == 0)) begin
          ex_cs = 0;
          ex_we = !wr_n;
        end
      end
      if (!rd_n) begin
        if (mem && ssl) begin
          ex_oe = 1; ex_dout = (~m_sec[slot]) & 'hFF;
        end else if (io && (a % 256) == 'hA8) begin
          ex_oe = 1; ex_dout = m_prim;
        end else if (io && (a % 256) >= 'hFC) begin
          ex_oe = 1; ex_dout = ('hFF & ~SEG_MASK) | m_seg[(a % 256) - 'hFC];
        end
      end
    end
    cmp({tag, ".sltsl_n"}, int'(sltsl_n), ex_sl);
    cmp({tag, ".subsl_n"}, int'(subsl_n), ex_sub);
    cmp({tag, ".mapper_cs_n"}, int'(mapper_cs_n), ex_cs);
    cmp({tag, ".mapper_we"}, int'(mapper_we), ex_we);
    cmp({tag, ".d_oe"}, int'(d_oe), ex_oe);
    if (ex_oe == 1) cmp({tag, ".d_out"}, int'(d_out), ex_dout);
    if (ex_cs == 0) cmp({tag, ".mapper_addr"}, int'(mapper_addr), ex_maddr);
  endtask

  task automatic bus_idle();
    mreq_n = 1; iorq_n = 1; rd_n = 1; wr_n = 1; m1_n = 1; rfrsh_n = 1;
  endtask

  // One bus cycle; writes may be stretched by wait states while the data
  // bus changes, which must not cause a second commit.
  task automatic cycle(bit io, bit wr, int a, int d, int waits, string tag);
    @(negedge clk);
    addr = 16'(a); d_from_cpu = 8'(d);
    if (io) iorq_n = 0; else mreq_n = 0;
    rd_n = wr; wr_n = !wr;
    #1 check(tag);
    @(posedge clk);
    if (wr) model_write(a, d, io);
    for (int w = 0; w < waits; w++) begin
      @(negedge clk);
      d_from_cpu = 8'(~d);
      #1 check({tag, ".wait"});
      @(posedge clk);
    end
    @(negedge clk);
    bus_idle();
    #1 check({tag, ".idle"});
    $display("txn %s io=%0d wr=%0d addr=%04h data=%02h waits=%0d", tag, io, wr, a, d, waits);
  endtask

  initial begin
    model_reset();
    bus_idle();
    // Outputs held inactive while in reset, even with a live bus cycle.
    #2;
    addr = 16'h0000; mreq_n = 0; rd_n = 0;
    #1 check("in_reset");
    cmp("in_reset.sltsl_raw", int'(sltsl_n), 'hF);
    bus_idle();
    repeat (2) @(negedge clk);
    reset_n = 1;

    cycle(1, 0, 'hA8, 0, 0, "rd_a8_reset");
    cycle(1, 0, 'hFF, 0, 0, "rd_ff_reset");
    cycle(0, 0, 'h0000, 0, 0, "rd_0000");
    cycle(1, 1, 'hA8, 'hC0, 0, "out_a8_c0");
    cycle(0, 0, 'hC000, 0, 0, "rd_c000");
    cmp("rd_c000.prim_model", m_prim, 'hC0);
    cycle(0, 1, 'hFFFF, 'h55, 0, "wr_ffff_55");
    cycle(0, 0, 'hFFFF, 0, 0, "rd_ffff");
    cycle(1, 1, 'hA8, 'hCC, 0, "out_a8_cc");
    cycle(0, 0, 'h4000, 0, 0, "rd_4000");
    cycle(1, 1, 'hFD, 'h0B, 0, "out_fd_0b");
    cycle(1, 0, 'hFD, 0, 0, "rd_fd");
    cycle(0, 1, 'hFFFF, 'h00, 0, "wr_ffff_00");
    cycle(0, 1, 'h4123, 'h99, 0, "wr_4123");
    cycle(1, 1, 'hA8, 'hF3, 3, "out_a8_wait3");
    cycle(1, 0, 'hA8, 0, 0, "rd_a8_after_wait");
    // A8h change of page 3 followed at once by an FFFFh access.
    cycle(1, 1, 'hA8, 'h33, 0, "out_a8_33");
    cycle(0, 0, 'hFFFF, 0, 0, "rd_ffff_unexp");
    cycle(1, 1, 'hA8, 'hC3, 0, "out_a8_c3");
    cycle(0, 0, 'hFFFF, 0, 0, "rd_ffff_exp");

    // Refresh at C000h selects nothing.
    @(negedge clk);
    addr = 16'hC000; mreq_n = 0; rfrsh_n = 0;
    #1 check("refresh_c000");
    @(negedge clk);
    bus_idle();
    $display("txn refresh addr=c000");

    // Reset asserted during an A8h write discards it.
    @(negedge clk);
    addr = 16'h00A8; d_from_cpu = 8'h5A; iorq_n = 0; wr_n = 0;
    #1 reset_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus_idle();
    @(negedge clk);
    reset_n = 1;
    $display("txn reset_mid_write addr=00a8 data=5a");
    cycle(1, 0, 'hA8, 0, 0, "rd_a8_after_reset");
    cycle(1, 0, 'hFC, 0, 0, "rd_fc_after_reset");

    // Randomized traffic.
    for (int n = 0; n < 250; n++) begin
      int kind, a, d, w;
      kind = int'($urandom_range(0, 9));
      d = int'($urandom_range(0, 255));
      w = int'($urandom_range(0, 3));
      if (kind < 5) begin
        if ($urandom_range(0, 3) == 0) a = 'hFFFF;
        else a = int'($urandom_range(0, 65535));
        cycle(0, kind[0], a, d, w, "rnd_mem");
      end else if (kind < 9) begin
        case ($urandom_range(0, 5))
          0, 1:    a = 'hA8;
          2:       a = 'hFC + int'($urandom_range(0, 3));
          3:       a = 'hFF;
          default: a = int'($urandom_range(0, 65535));
        endcase
        cycle(1, kind[0], a, d, w, "rnd_io");
      end else begin
        @(negedge clk);
        addr = 16'($urandom_range(0, 65535)); mreq_n = 0; rfrsh_n = 0;
        #1 check("rnd_refresh");
        @(negedge clk);
        bus_idle();
        $display("txn rnd_refresh addr=%04h", addr);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/msx_slot_expander.md
# msx_slot_expander

Parametrised primary/secondary slot controller with integrated RAM memory-mapper registers, the next-generation replacement for the fixed four-slot `memory_mapper` used in the MSX1 top level. It decodes CPU memory and I/O cycles into per-slot and per-subslot select strobes. It owns the primary slot register (port A8h), per-slot secondary slot registers (memory FFFFh), and four mapper segment registers (ports FCh–FFh). It sits between the T80 bus and the slot devices (BIOS ROM, RAM, cartridges).

## Interface
- `EXPANDED`, 4'b1000: bit n=1 → primary slot n is expanded (has FFFFh subslot register).
- `SEG_BITS`, 3: mapper segment register width (1–8); mapped RAM size = 2^SEG_BITS × 16 KB.
- `MAPPER_SLOT`, 3: primary slot holding mapped RAM.
- `MAPPER_SUB`, 0: subslot holding mapped RAM (ignored if that slot is not expanded).
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `addr` in 16: CPU address.
- `d_from_cpu` in 8: CPU write data.
- `mreq_n`, `iorq_n`, `rd_n`, `wr_n`, `m1_n`, `rfrsh_n` in 1 each: T80 bus strobes.
- `d_out` out 8: read data for A8h, FFFFh, FCh–FFh.
- `d_oe` out 1: `d_out` valid; the top-level data mux gives it priority.
- `sltsl_n` out 4: primary slot selects, active-low.
- `subsl_n` out 16: subslot selects, index 4×slot+sub, active-low; only bits of expanded slots ever assert.
- `mapper_cs_n` out 1: mapped-RAM select, active-low.
- `mapper_addr` out SEG_BITS+14: `{segment, addr[13:0]}`.
- `mapper_we` out 1: write enable for mapped RAM.

## Operation
- page = `addr[15:14]`; slot = `prim[2*page+1:2*page]`; sub = `secreg[slot][2*page+1:2*page]`.
- Memory cycle = `~mreq_n & rfrsh_n`. During refresh no select asserts.
- `sltsl_n[slot]`=0 during a memory cycle. `subsl_n[4*slot+sub]`=0 if `EXPANDED[slot]`.
- FFFFh in an expanded slot (page 3) is a register, not memory. Slot and subslot selects stay high for that address; reads give `d_out = ~secreg[slot]` with `d_oe`=1.
- FFFFh in an unexpanded slot passes through to memory as normal.
- I/O decode: `~iorq_n & m1_n`, `addr[7:0]` only.
  - A8h read returns `prim`.
  - FCh+p read returns `{ones, seg[p]}`; unused high bits read as 1.
- Mapped RAM:
  - `mapper_cs_n`=0 when slot == MAPPER_SLOT (and sub == MAPPER_SUB if expanded) during a memory cycle, excluding the FFFFh register.
  - `mapper_we` = `~mapper_cs_n & ~wr_n`.
- Write-commit FSM, states IDLE → HELD:
  - IDLE: on a clk edge with a decoded register write (`wr_n`=0 and target decoded), latch `d_from_cpu` into the target and go to HELD.
  - HELD: wait for `wr_n`=1 or the strobe (`mreq_n`/`iorq_n`) to deassert, then return to IDLE.
  - Exactly one commit per bus write, regardless of wait states.
- FCh–FFh writes store `d_from_cpu[SEG_BITS-1:0]`.
- FFFFh writes go to `secreg[slot of page 3]` at the time of the write.

## Timing
- Selects, `d_out` and `d_oe` are combinational from registers and bus; zero latency.
- Register writes take effect on the clk edge after `wr_n` falls. Selects reflect the new value from the next cycle.
- Reset (async, `reset_n`=0): `prim`=00h, all `secreg`=00h, `seg[0..3]`=3,2,1,0 (masked to SEG_BITS), FSM=IDLE.
- While in reset: all `*_n` outputs 1, `d_oe`=0, `mapper_we`=0.
- Reset asserted mid-write discards the write; no partial commit.
- A write to A8h that changes page 3's slot: an immediately following FFFFh access uses the new slot.
- Segment values wrap modulo 2^SEG_BITS; upper data bits are ignored.

## Structure
- Shared package `msx_pkg`: port constants (A8h, FCh–FFh, FFFFh), reset segment table, page/slot field helper functions.
- One natural sub-module: `msx_bus_wr_commit` (the IDLE/HELD single-commit FSM), reused later for other I/O register blocks.

## Test plan
- Reset → `prim`=00h; A8h read = 00h; FFh read with SEG_BITS=3 = F8h; `sltsl_n[0]`=0 on a memory read at 0000h.
- OUT A8h,0xC0, then read C000h → `sltsl_n`=0111b; with slot 3 expanded, `subsl_n[12]`=0.
- Write FFFFh=0x55 with slot 3 in page 3 → FFFFh reads AAh; read at 4000h asserts `subsl_n[13]`; `sltsl_n` stays high during the FFFFh access.
- OUT FDh,0x0B with SEG_BITS=3, then write 4123h in the mapper slot → `mapper_addr`=0C123h (segment 3, 03h shown), `mapper_we`=1 for the write only.
- Write held for 3 wait states → exactly one commit; a refresh cycle at C000h → no select asserts.
- `reset_n` low in the middle of an A8h write → `prim` remains 00h after release.
